// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of the single-port data memory.
// Each access takes one ACCESS cycle; the owning port sees a one-cycle ack.
module dmem_arbiter #(
  parameter int DEPTH = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        r0_req,
  input  logic        r0_we,
  input  logic [3:0]  r0_mask,
  input  logic [31:0] r0_addr,
  input  logic [31:0] r0_wdata,
  output logic        r0_ack,
  output logic        r0_err,
  output logic [31:0] r0_rdata,
  input  logic        r1_req,
  input  logic        r1_we,
  input  logic [3:0]  r1_mask,
  input  logic [31:0] r1_addr,
  input  logic [31:0] r1_wdata,
  output logic        r1_ack,
  output logic        r1_err,
  output logic [31:0] r1_rdata,
  output logic        dmem_sel,
  output logic        wr,
  output logic [3:0]  mask,
  output logic [31:0] addr,
  output logic [31:0] dmem_data_wr,
  input  logic [31:0] dmem_data_rd
);

  localparam logic [31:0] LIMIT = 32'(DEPTH * 4);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t      state_reg, state_next;
  logic        owner_reg, owner_next;
  logic        last_grant_reg, last_grant_next;
  logic        in_range_reg, in_range_next;
  logic        access;

  logic [1:0]  req_v;
  logic [1:0]  we_v;
  logic [3:0]  mask_v  [2];
  logic [31:0] addr_v  [2];
  logic [31:0] wdata_v [2];

  assign req_v      = {r1_req, r0_req};
  assign we_v       = {r1_we, r0_we};
  assign mask_v[0]  = r0_mask;
  assign mask_v[1]  = r1_mask;
  assign addr_v[0]  = r0_addr;
  assign addr_v[1]  = r1_addr;
  assign wdata_v[0] = r0_wdata;
  assign wdata_v[1] = r1_wdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= IDLE;
      owner_reg      <= 1'b0;
      last_grant_reg <= 1'b1;
      in_range_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      owner_reg      <= owner_next;
      last_grant_reg <= last_grant_next;
      in_range_reg   <= in_range_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    owner_next      = owner_reg;
    last_grant_next = last_grant_reg;
    in_range_next   = in_range_reg;
    case (state_reg)
      IDLE: begin
        if (|req_v) begin
          // On contention the port that did not win last time goes first.
          owner_next    = (&req_v) ? ~last_grant_reg : req_v[1];
          in_range_next = addr_v[owner_next] < LIMIT;
          state_next    = ACCESS;
        end
      end
      ACCESS: begin
        last_grant_next = owner_reg;
        state_next      = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Memory strobes are gated by reset so an aborted access never writes.
  assign access       = (state_reg == ACCESS);
  assign dmem_sel     = access & in_range_reg & rst;
  assign wr           = dmem_sel & we_v[owner_reg];
  assign mask         = access ? mask_v[owner_reg]  : 4'h0;
  assign addr         = access ? addr_v[owner_reg]  : 32'h0;
  assign dmem_data_wr = access ? wdata_v[owner_reg] : 32'h0;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : port_g
      logic        ack_reg;
      logic        err_reg;
      logic [31:0] rdata_reg;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          ack_reg   <= 1'b0;
          err_reg   <= 1'b0;
          rdata_reg <= 32'h0;
        end else if (access && (owner_reg == 1'(gi))) begin
          ack_reg   <= 1'b1;
          err_reg   <= ~in_range_reg;
          rdata_reg <= (~we_v[gi] & in_range_reg) ? dmem_data_rd : 32'h0;
        end else begin
          ack_reg   <= 1'b0;
          err_reg   <= 1'b0;
        end
      end
    end
  endgenerate

  assign r0_ack   = port_g[0].ack_reg;
  assign r0_err   = port_g[0].err_reg;
  assign r0_rdata = port_g[0].rdata_reg;
  assign r1_ack   = port_g[1].ack_reg;
  assign r1_err   = port_g[1].err_reg;
  assign r1_rdata = port_g[1].rdata_reg;

endmodule
